// File: rtl/hack_ram_reader_pkg.sv
// Shared types and default widths for the Hack RAM8 burst reader.
package hack_ram_reader_pkg;

    localparam int HACK_DATA_W      = 16;
    localparam int HACK_RAM8_ADDR_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HOLD   = 2'd2,
        FINISH = 2'd3
    } state_e;

endpackage

// File: rtl/hack_ram_reader_csum.sv
// Running modulo-2^DATA_WIDTH sum of streamed words; clear wins over enable.
module hack_ram_reader_csum
    import hack_ram_reader_pkg::*;
#(
    parameter int DATA_WIDTH = HACK_DATA_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic                  en_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] sum_o
);

    logic [DATA_WIDTH-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr_i)     sum_d = '0;
        else if (en_i) sum_d = sum_q + data_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) sum_q <= '0;
        else        sum_q <= sum_d;
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/hack_ram_reader.sv
// Burst read master for a Hack RAM8-style memory, streaming words over valid/ready.
// Optional burst checksum enabled by defining HACK_RAM_READER_CHECKSUM_EN.
module hack_ram_reader
    import hack_ram_reader_pkg::*;
#(
    parameter int DATA_WIDTH = HACK_DATA_W,
    parameter int ADDR_WIDTH = HACK_RAM8_ADDR_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic [ADDR_WIDTH:0]   len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] address_o,
    output logic                  load_o,
    input  logic [DATA_WIDTH-1:0] ram_data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  last_o,
    output logic [DATA_WIDTH-1:0] checksum_o
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH:0]   rem_q, rem_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  is_last;
    logic                  hs;
    logic                  accept;

    assign is_last = (rem_q == '0);
    assign hs      = (state_q == HOLD) && ready_i;
    assign accept  = (state_q == IDLE) && start_i;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = (len_i == '0) ? FINISH : FETCH;
            FETCH:   state_d = HOLD;
            HOLD:    if (ready_i && is_last) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A word is pulled from RAM in FETCH and on every non-final handshake,
    // so the read address always points at the word that would come next.
    always_comb begin
        ptr_d  = ptr_q;
        rem_d  = rem_q;
        data_d = data_q;
        if (accept) begin
            ptr_d = base_i;
            rem_d = len_i;
        end else if ((state_q == FETCH) || (hs && !is_last)) begin
            data_d = ram_data_i;
            ptr_d  = ptr_q + ADDR_WIDTH'(1);
            rem_d  = rem_q - (ADDR_WIDTH+1)'(1);
        end
    end

    always_comb begin
        busy_o    = (state_q != IDLE);
        done_o    = (state_q == FINISH);
        valid_o   = (state_q == HOLD);
        last_o    = (state_q == HOLD) && is_last;
        address_o = ptr_q;
        load_o    = 1'b0;
        data_o    = data_q;
    end

`ifdef HACK_RAM_READER_CHECKSUM_EN
    hack_ram_reader_csum #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_csum (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (accept),
        .en_i   (hs),
        .data_i (data_q),
        .sum_o  (checksum_o)
    );
`else
    assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_hack_ram_reader.sv
// Directed self-checking bench for hack_ram_reader with a behavioural RAM8.
module tb_hack_ram_reader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  base;
    logic [3:0]  len;
    logic        busy, done, load, valid, ready, last;
    logic [2:0]  address;
    logic [15:0] ram_data, data, checksum;
    logic [15:0] mem [8];

    int checks = 0;
    int errors = 0;

    hack_ram_reader dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .base_i     (base),
        .len_i      (len),
        .busy_o     (busy),
        .done_o     (done),
        .address_o  (address),
        .load_o     (load),
        .ram_data_i (ram_data),
        .data_o     (data),
        .valid_o    (valid),
        .ready_i    (ready),
        .last_o     (last),
        .checksum_o (checksum)
    );

    assign ram_data = mem[address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1ns later; load must be 0 every cycle.
    task automatic step();
        @(posedge clk);
        #1;
        check("load_o", 32'(load), 0);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_done"},  32'(done), 0);
        check({tag, "_addr"},  32'(address), 0);
        check({tag, "_data"},  32'(data), 0);
        check({tag, "_valid"}, 32'(valid), 0);
        check({tag, "_last"},  32'(last), 0);
        check({tag, "_csum"},  32'(checksum), 0);
    endtask

    function automatic logic [31:0] csum_exp(input int s);
`ifdef HACK_RAM_READER_CHECKSUM_EN
        return 32'(s % 65536);
`else
        return 0;
`endif
    endfunction

    int exp1 [4] = '{7, 2, 3, 99};
    int bp_rdy  [8] = '{1, 0, 0, 1, 0, 1, 0, 0};
    int bp_data [8] = '{2, 2, 2, 3, 3, 99, 99, 99};

    initial begin
        rst = 1'b0; start = 1'b0; base = '0; len = '0; ready = 1'b1;
        for (int i = 0; i < 8; i++) mem[i] = 16'hdead;
        mem[3] = 16'd7; mem[4] = 16'd2; mem[5] = 16'd3; mem[6] = 16'd99;
        step(); step();
        check_idle_zero("reset");
        rst = 1'b1;
        step();

        // Burst 1: base 3, len 4, constant ready.
        start = 1'b1; base = 3'd3; len = 4'd4; ready = 1'b1;
        step();
        check("b1_fetch_busy", 32'(busy), 1);
        check("b1_fetch_valid", 32'(valid), 0);
        check("b1_fetch_addr", 32'(address), 3);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("b1_valid", 32'(valid), 1);
            check("b1_data", 32'(data), 32'(exp1[i]));
            check("b1_last", 32'(last), (i == 3) ? 1 : 0);
        end
        step();
        check("b1_done", 32'(done), 1);
        check("b1_valid_off", 32'(valid), 0);
        check("b1_busy_fin", 32'(busy), 1);
        check("b1_csum", 32'(checksum), csum_exp(111));
        step();
        check("b1_done_off", 32'(done), 0);
        check("b1_busy_off", 32'(busy), 0);
        check("b1_csum_hold", 32'(checksum), csum_exp(111));

        // Burst 2: same window, backpressure, with a stray start mid-burst.
        start = 1'b1; base = 3'd3; len = 4'd4;
        step();
        start = 1'b0; ready = 1'b0;
        step();
        check("b2_first", 32'(data), 7);
        check("b2_first_valid", 32'(valid), 1);
        for (int i = 0; i < 8; i++) begin
            ready = bp_rdy[i][0];
            if (i == 2) begin start = 1'b1; base = 3'd0; len = 4'd1; end
            step();
            start = 1'b0;
            check("b2_data", 32'(data), 32'(bp_data[i]));
            check("b2_valid", 32'(valid), 1);
            check("b2_last", 32'(last), (bp_data[i] == 99) ? 1 : 0);
        end
        ready = 1'b1;
        step();
        check("b2_done", 32'(done), 1);
        check("b2_csum", 32'(checksum), csum_exp(111));
        step();
        check("b2_idle", 32'(busy), 0);

        // Burst 3: wrap from address 6.
        for (int i = 0; i < 8; i++) mem[i] = 16'(i + 10);
        start = 1'b1; base = 3'd6; len = 4'd4;
        step();
        start = 1'b0;
        check("b3_fetch_addr", 32'(address), 6);
        for (int i = 0; i < 4; i++) begin
            step();
            check("b3_data", 32'(data), 32'(((6 + i) % 8) + 10));
            check("b3_addr", 32'(address), 32'((7 + i) % 8));
        end
        step();
        check("b3_done", 32'(done), 1);
        check("b3_csum", 32'(checksum), csum_exp(54));
        step();

        // Burst 4: zero length.
        start = 1'b1; base = 3'd2; len = 4'd0;
        step();
        start = 1'b0;
        check("b4_done", 32'(done), 1);
        check("b4_valid", 32'(valid), 0);
        check("b4_csum", 32'(checksum), 0);
        step();
        check("b4_done_off", 32'(done), 0);
        check("b4_busy_off", 32'(busy), 0);

        // Burst 5: full memory sweep from base 0.
        start = 1'b1; base = 3'd0; len = 4'd8;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check("b5_data", 32'(data), 32'(i + 10));
            check("b5_last", 32'(last), (i == 7) ? 1 : 0);
        end
        step();
        check("b5_done", 32'(done), 1);
        check("b5_csum", 32'(checksum), csum_exp(108));
        step();

        // Burst 6: reset during HOLD aborts without done.
        start = 1'b1; base = 3'd3; len = 4'd4; ready = 1'b0;
        step();
        start = 1'b0;
        step();
        check("b6_hold_valid", 32'(valid), 1);
        check("b6_hold_data", 32'(data), 13);
        rst = 1'b0;
        step();
        check_idle_zero("b6_abort");
        rst = 1'b1; ready = 1'b1;
        step();
        check("b6_no_done", 32'(done), 0);
        check("b6_no_busy", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
